// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, default widths,
// CPU reset address and instruction word size.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, instruction} pairs with clear,
// occupancy count and registered head; storage is zeroed on reset.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  valid_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign valid_o = (count_q != '0);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch into a decode FIFO, with flush.
// Optional macro INST_FETCH_BYPASS_EN forwards a response to decode when the FIFO is empty.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              dec_valid_o,
    output logic [ADDR_W-1:0] dec_pc_o,
    output logic [DATA_W-1:0] dec_inst_o,
    input  logic              dec_ready_i
);
    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e              state_q, state_d;
    logic                      req_q, req_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic                      resp, push, pop, bypass, fifo_valid;
    logic [CNT_W-1:0]          fifo_count, count_after;
    logic [ADDR_W+DATA_W-1:0]  head;

    assign resp        = (state_q == ST_WAIT) & imem_rvalid_i;
    assign push        = resp & ~flush_i & ~bypass;
    assign pop         = fifo_valid & dec_ready_i;
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_i;
    assign stall_o     = ce_i & ~(req_q & imem_gnt_i);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (ce_i && !flush_i && (fifo_count < FULL_CNT)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    pc_d    = pc_i;
                    req_d   = 1'b0;
                    state_d = flush_i ? ST_DRAIN : ST_WAIT;
                end else if (flush_i) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Re-issue only if the entry just written (net of a same-cycle pop) leaves room.
                if (imem_rvalid_i) begin
                    if (!flush_i && ce_i && (count_after < FULL_CNT)) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pc_q    <= ADDR_W'(RESET_ADDR);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .data_i  ({pc_q, imem_rdata_i}),
        .head_o  (head),
        .count_o (fifo_count),
        .valid_o (fifo_valid)
    );

`ifdef INST_FETCH_BYPASS_EN
    assign bypass      = resp & dec_ready_i & ~flush_i & ~fifo_valid;
    assign dec_valid_o = fifo_valid | bypass;
    assign dec_pc_o    = bypass ? pc_q : head[ADDR_W+DATA_W-1:DATA_W];
    assign dec_inst_o  = bypass ? imem_rdata_i : head[DATA_W-1:0];
`else
    assign bypass      = 1'b0;
    assign dec_valid_o = fifo_valid;
    assign dec_pc_o    = head[ADDR_W+DATA_W-1:DATA_W];
    assign dec_inst_o  = head[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a reactive memory/PC model plus an in-order
// {pc, inst} scoreboard, driven by directed scenarios and a randomized run.
module tb_inst_fetch;
    import fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        stall_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_inst_o;
    logic        dec_ready_i;

    always #5 clk_i = ~clk_i;

    inst_fetch #(
        .DEPTH  (2),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .stall_o       (stall_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .dec_valid_o   (dec_valid_o),
        .dec_pc_o      (dec_pc_o),
        .dec_inst_o    (dec_inst_o),
        .dec_ready_i   (dec_ready_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected decode stream and logs of observed activity
    ent_t        exp_q[$];
    logic [31:0] hs_pc_q[$];
    int          hs_cyc_q[$];
    int          gnt_cyc_q[$];
    int          n_grants = 0;

    // Memory model state
    bit          pend = 0;
    bit          pend_drop = 0;
    int          pend_age = 0;
    int          req_age = 0;
    logic [31:0] pend_pc = '0;
    int          gnt_lat = 0, rv_lat = 0, cur_gnt = 0, cur_rv = 0;
    bit          rand_lat = 0;
    bit          chk_ok = 0;

    logic        last_req, last_stall, last_granted;
    logic [31:0] last_addr;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_lat(input int g, input int r);
        gnt_lat = g;
        rv_lat  = r;
        cur_gnt = g;
        cur_rv  = r;
    endtask

    task automatic clear_logs();
        hs_pc_q.delete();
        hs_cyc_q.delete();
        gnt_cyc_q.delete();
    endtask

    // One clock cycle: entered and left at a negative edge.
    task automatic tick();
        bit deliver = 0;
        bit granted = 0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        if (!rst_i) begin
            exp_q.delete();
            if (pend) pend_drop = 1;
            req_age = 0;
        end
        if (pend) begin
            if (pend_age >= cur_rv) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = $urandom;
                deliver       = 1;
                pend          = 0;
            end else begin
                pend_age++;
            end
        end else if (rst_i && imem_req_o) begin
            if (req_age >= cur_gnt) begin
                imem_gnt_i = 1'b1;
                granted    = 1;
                pend       = 1;
                pend_age   = 0;
                pend_drop  = 0;
                pend_pc    = pc_i;
                req_age    = 0;
                n_grants++;
                gnt_cyc_q.push_back(cyc);
                cur_rv  = rand_lat ? int'($urandom_range(0, 3)) : rv_lat;
                cur_gnt = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
            end else begin
                req_age++;
            end
        end
        #1;
        last_req     = imem_req_o;
        last_stall   = stall_o;
        last_addr    = imem_addr_o;
        last_granted = granted;
        if (rst_i && chk_ok) begin
            n_tests++;
            if (dec_valid_o !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid_o, exp_q.size() != 0);
            end
            if (dec_valid_o === 1'b1 && exp_q.size() != 0) begin
                n_tests++;
                if (dec_pc_o !== exp_q[0].pc || dec_inst_o !== exp_q[0].inst) begin
                    n_fail++;
                    $display("FAIL dec_head cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                             cyc, dec_pc_o, dec_inst_o, exp_q[0].pc, exp_q[0].inst);
                end
                if (dec_ready_i) begin
                    hs_pc_q.push_back(exp_q[0].pc);
                    hs_cyc_q.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (deliver && !pend_drop && !flush_i && rst_i)
            exp_q.push_back('{pc: pend_pc, inst: imem_rdata_i});
        if (flush_i) begin
            exp_q.delete();
            if (pend) pend_drop = 1;
        end
        chk_ok = rst_i;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        if (granted && ce_i) pc_i = pc_i + 32'(WORD_BYTES);
    endtask

    task automatic quiesce();
        bit quiet = 0;
        ce_i = 1'b0; flush_i = 1'b0; dec_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!pend && exp_q.size() == 0 && !imem_req_o && !dec_valid_o) begin
                quiet = 1;
                break;
            end
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL quiesce: got req=%b valid=%b expected both 0 within 40 cycles", imem_req_o, dec_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; ce_i = 1'b1; flush_i = 1'b0; dec_ready_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; pc_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (dec_valid_o !== 1'b0 || dec_pc_o !== '0 || dec_inst_o !== '0) begin
            n_fail++;
            $display("FAIL reset_dec: got valid=%b pc=%h inst=%h expected all 0", dec_valid_o, dec_pc_o, dec_inst_o);
        end
        n_tests++;
        if (imem_req_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_stall: got req=%b stall=%b expected req=0 stall=1", imem_req_o, stall_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if (imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_req: got %b expected 1", imem_req_o);
        end
        chk_ok = 1;
    endtask

    task automatic test_stream();
        int g;
        set_lat(0, 0);
        dec_ready_i = 1'b1; ce_i = 1'b1;
        clear_logs();
        repeat (8) tick();
        n_tests++;
        if (hs_pc_q.size() < 3 || gnt_cyc_q.size() < 1) begin
            n_fail++;
            $display("FAIL stream_count: got %0d handshakes expected at least 3", hs_pc_q.size());
        end else begin
            g = gnt_cyc_q[0];
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (hs_pc_q[i] !== 32'(4 * i) || hs_cyc_q[i] != g + 2 + 2 * i) begin
                    n_fail++;
                    $display("FAIL stream_%0d: got pc=%h cyc=%0d expected pc=%h cyc=%0d",
                             i, hs_pc_q[i], hs_cyc_q[i], 32'(4 * i), g + 2 + 2 * i);
                end
            end
        end
        quiesce();
    endtask

    task automatic test_backpressure();
        int g0;
        set_lat(0, 0);
        pc_i = '0; dec_ready_i = 1'b0; ce_i = 1'b1;
        clear_logs();
        g0 = n_grants;
        repeat (10) tick();
        n_tests++;
        if (n_grants - g0 != 2 || imem_req_o !== 1'b0 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: got grants=%0d req=%b stall=%b expected grants=2 req=0 stall=1",
                     n_grants - g0, imem_req_o, stall_o);
        end
        n_tests++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", dec_valid_o, dec_pc_o);
        end
        dec_ready_i = 1'b1;
        repeat (6) tick();
        n_tests++;
        if (hs_pc_q.size() == 0 || hs_pc_q[0] !== 32'h0 || n_grants - g0 < 3) begin
            n_fail++;
            $display("FAIL bp_resume: got handshakes=%0d grants=%0d expected head 0 popped and a 3rd grant",
                     hs_pc_q.size(), n_grants - g0);
        end
        quiesce();
    endtask

    task automatic test_gnt_delay();
        int  stalled = 0;
        bit  got = 0;
        set_lat(3, 0);
        pc_i = 32'h200; dec_ready_i = 1'b1; ce_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_granted) begin
                got = 1;
                break;
            end
            if (last_req) begin
                stalled++;
                n_tests++;
                if (last_stall !== 1'b1 || last_addr !== 32'h200) begin
                    n_fail++;
                    $display("FAIL gnt_wait: got stall=%b addr=%h expected stall=1 addr=00000200", last_stall, last_addr);
                end
            end
        end
        n_tests++;
        if (!got || stalled != 3 || last_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL gnt_delay: got granted=%b stalled=%0d stall_on_gnt=%b expected 1/3/0", got, stalled, last_stall);
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_granted) begin
                got = 1;
                break;
            end
        end
        n_tests++;
        if (!got || last_addr !== 32'h204) begin
            n_fail++;
            $display("FAIL gnt_next_addr: got granted=%b addr=%h expected 1/00000204", got, last_addr);
        end
        quiesce();
        set_lat(0, 0);
    endtask

    task automatic test_flush_wait();
        bit got = 0;
        set_lat(0, 2);
        pc_i = 32'h300; dec_ready_i = 1'b1; ce_i = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = last_granted;
        end
        tick();
        flush_i = 1'b1; pc_i = 32'h400;
        tick();
        flush_i = 1'b0;
        clear_logs();
        tick();
        n_tests++;
        if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wait_drop: got valid=%b req=%b expected 0/0", dec_valid_o, imem_req_o);
        end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = last_granted;
        end
        n_tests++;
        if (!got || last_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL flush_wait_refetch: got granted=%b addr=%h expected 1/00000400", got, last_addr);
        end
        repeat (5) tick();
        n_tests++;
        if (hs_pc_q.size() == 0 || hs_pc_q[0] !== 32'h400) begin
            n_fail++;
            $display("FAIL flush_wait_deliver: got %0d handshakes expected first pc 00000400", hs_pc_q.size());
        end
        quiesce();
        set_lat(0, 0);
    endtask

    task automatic test_flush_rvalid_pop();
        int g0;
        set_lat(0, 0);
        pc_i = 32'h500; dec_ready_i = 1'b0; ce_i = 1'b1;
        g0 = n_grants;
        for (int i = 0; i < 20 && n_grants - g0 < 2; i++) tick();
        clear_logs();
        dec_ready_i = 1'b1; flush_i = 1'b1; ce_i = 1'b0;
        tick();
        flush_i = 1'b0;
        n_tests++;
        if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b0 || hs_pc_q.size() != 1) begin
            n_fail++;
            $display("FAIL flush_pop: got valid=%b req=%b pops=%0d expected 0/0/1", dec_valid_o, imem_req_o, hs_pc_q.size());
        end
        tick();
        n_tests++;
        if (dec_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pop_empty: got valid=%b expected 0", dec_valid_o);
        end
        ce_i = 1'b1;
        tick();
        n_tests++;
        if (imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pop_idle: got req=%b expected 1", imem_req_o);
        end
        quiesce();
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        set_lat(0, 2);
        pc_i = 32'h600; dec_ready_i = 1'b1; ce_i = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = last_granted;
        end
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1; pc_i = 32'h700;
        clear_logs();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = last_granted;
        end
        n_tests++;
        if (!got || last_addr !== 32'h700) begin
            n_fail++;
            $display("FAIL reset_mid_refetch: got granted=%b addr=%h expected 1/00000700", got, last_addr);
        end
        repeat (5) tick();
        n_tests++;
        if (hs_pc_q.size() == 0 || hs_pc_q[0] !== 32'h700) begin
            n_fail++;
            $display("FAIL reset_mid_deliver: got %0d handshakes expected first pc 00000700", hs_pc_q.size());
        end
        quiesce();
        set_lat(0, 0);
    endtask

    task automatic test_random();
        rand_lat = 1;
        cur_gnt  = 1;
        cur_rv   = 0;
        for (int i = 0; i < 400; i++) begin
            ce_i        = ($urandom_range(0, 3) != 0);
            dec_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            if (flush_i) pc_i = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        quiesce();
        rand_lat = 0;
        set_lat(0, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_delay();
        test_flush_wait();
        test_flush_rvalid_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
